// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches from a handshaked instruction memory and buffers
// {pc,instr} pairs for the IF/ID register, with hazard stall hold and branch flush.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_data_i,
  output logic                       valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, FULL, DISCARD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_n;
  state_t          state, state_n;
  logic [31:0]     fetch_pc, fetch_pc_n, addr, addr_n;
  logic            push, pop, room;

  always_comb begin
    push       = (state == REQ) && mem_ack_i && !flush_i;
    pop        = (count != '0) && !stall_i && !flush_i;
    count_n    = flush_i ? '0 : count + CW'(push) - CW'(pop);
    room       = count_n < CW'(DEPTH);
    fetch_pc_n = flush_i ? redirect_pc_i : (push ? fetch_pc + 32'd4 : fetch_pc);

    state_n = state;
    case (state)
      IDLE:    if (start_i && room) state_n = REQ;
      REQ: begin
        if (flush_i)        state_n = mem_ack_i ? (start_i ? REQ : IDLE) : DISCARD;
        else if (mem_ack_i) state_n = !room ? FULL : (start_i ? REQ : IDLE);
      end
      FULL:    if (room) state_n = start_i ? REQ : IDLE;
      // the stale response must still be absorbed before the redirected fetch goes out
      DISCARD: if (mem_ack_i) state_n = REQ;
      default: state_n = IDLE;
    endcase

    // address follows fetch_pc except while a dropped request is still outstanding
    addr_n = (state_n == DISCARD) ? addr : fetch_pc_n;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      addr     <= RESET_PC;
    end else begin
      state    <= state_n;
      count    <= count_n;
      fetch_pc <= fetch_pc_n;
      addr     <= addr_n;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo[wr_ptr] <= '{pc: addr, instr: mem_data_i};
  end

  assign mem_req_o  = (state == REQ) || (state == DISCARD);
  assign mem_addr_o = addr;
  assign valid_o    = (count != '0);
  assign instr_o    = valid_o ? fifo[rd_ptr].instr : NOP;
  assign pc_o       = valid_o ? fifo[rd_ptr].pc : 32'h0;
  assign count_o    = count;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed vector table, hand sequences for flush/reset
// corners, then random traffic against a queue-based reference model.
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, start, mem_req, mem_ack, valid, stall, flush;
  logic [31:0]   mem_addr, mem_data, instr, pc, redir;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
    .valid_o(valid), .instr_o(instr), .pc_o(pc),
    .stall_i(stall), .flush_i(flush), .redirect_pc_i(redir), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start, ack, stall, flush;
    logic [31:0] data, redir;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, pc;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input int e_cnt);
    check({tag, ".req"}, 32'(mem_req), 32'(e_req));
    if (e_req) check({tag, ".addr"}, mem_addr, e_addr);
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".instr"}, instr, e_instr);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".count"}, 32'(count), 32'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic [31:0] d,
                       input logic st, input logic f, input logic [31:0] r);
    start = s; mem_ack = a; mem_data = d; stall = st; flush = f; redir = r;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
  endtask

  function automatic vec_t mk(input logic s, input logic a, input logic st, input logic f,
                              input logic [31:0] d, input logic [31:0] r, input logic rq,
                              input logic [31:0] ad, input logic v, input logic [31:0] in,
                              input logic [31:0] p, input logic [2:0] c);
    vec_t x;
    x.start = s; x.ack = a; x.stall = st; x.flush = f; x.data = d; x.redir = r;
    x.req = rq; x.addr = ad; x.valid = v; x.instr = in; x.pc = p; x.cnt = c;
    return x;
  endfunction

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_fpc, m_raddr;
  logic        m_out, m_disc;

  task automatic model_step(input logic s, input logic a, input logic [31:0] d,
                            input logic st, input logic f, input logic [31:0] r);
    if (f) begin
      mq.delete();
      m_fpc = r;
      if (m_out && !a) m_disc = 1'b1;
      else begin
        m_out   = m_out ? (m_disc ? 1'b1 : s) : s;
        m_disc  = 1'b0;
        m_raddr = m_fpc;
      end
    end else begin
      if (mq.size() > 0 && !st) void'(mq.pop_front());
      if (m_out && a) begin
        if (m_disc) begin
          m_disc  = 1'b0;
          m_raddr = m_fpc;
        end else begin
          mq.push_back('{pc: m_raddr, instr: d});
          m_fpc   = m_fpc + 32'd4;
          m_out   = s && (mq.size() < DEPTH);
          m_raddr = m_fpc;
        end
      end else if (!m_out) begin
        m_out   = s && (mq.size() < DEPTH);
        m_raddr = m_fpc;
      end
    end
  endtask

  vec_t vt[14];

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    vt[0]  = mk(1,0,0,0, 32'h0,  0, 1, 32'h00, 0, 32'h13, 32'h00, 0);
    vt[1]  = mk(1,1,0,0, 32'hA0, 0, 1, 32'h04, 1, 32'hA0, 32'h00, 1);
    vt[2]  = mk(1,1,0,0, 32'hA1, 0, 1, 32'h08, 1, 32'hA1, 32'h04, 1);
    vt[3]  = mk(1,1,0,0, 32'hA2, 0, 1, 32'h0C, 1, 32'hA2, 32'h08, 1);
    vt[4]  = mk(1,1,1,0, 32'hA3, 0, 1, 32'h10, 1, 32'hA2, 32'h08, 2);
    vt[5]  = mk(1,1,1,0, 32'hA4, 0, 1, 32'h14, 1, 32'hA2, 32'h08, 3);
    vt[6]  = mk(1,1,1,0, 32'hA5, 0, 0, 32'h00, 1, 32'hA2, 32'h08, 4);
    vt[7]  = mk(1,0,1,0, 32'h0,  0, 0, 32'h00, 1, 32'hA2, 32'h08, 4);
    vt[8]  = mk(1,0,0,0, 32'h0,  0, 1, 32'h18, 1, 32'hA3, 32'h0C, 3);
    vt[9]  = mk(1,0,0,0, 32'h0,  0, 1, 32'h18, 1, 32'hA4, 32'h10, 2);
    vt[10] = mk(1,1,1,0, 32'hA6, 0, 1, 32'h1C, 1, 32'hA4, 32'h10, 3);
    vt[11] = mk(0,1,0,0, 32'hA7, 0, 0, 32'h00, 1, 32'hA5, 32'h14, 3);
    vt[12] = mk(0,0,0,0, 32'h0,  0, 0, 32'h00, 1, 32'hA6, 32'h18, 2);
    vt[13] = mk(1,0,1,0, 32'h0,  0, 1, 32'h20, 1, 32'hA6, 32'h18, 2);

    // reset held with start high: nothing issued
    do_reset();
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 0);
    rst = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].start, vt[i].ack, vt[i].data, vt[i].stall, vt[i].flush, vt[i].redir);
      step();
      check_outs($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].valid,
                 vt[i].instr, vt[i].pc, int'(vt[i].cnt));
    end

    // flush with request outstanding and no ack: address held, data dropped
    do_reset(); rst = 1'b1;
    drive(1, 0, 32'h0,  1, 0, 32'h0);   step();
    drive(1, 1, 32'hA0, 1, 0, 32'h0);   step();
    drive(1, 1, 32'hA1, 1, 0, 32'h0);   step();
    check_outs("t4.pre", 1, 32'h8, 1, 32'hA0, 32'h0, 2);
    drive(1, 0, 32'h0,  1, 1, 32'h100); step();
    check_outs("t4.flush", 1, 32'h8, 0, 32'h13, 32'h0, 0);
    drive(1, 0, 32'h0,  0, 0, 32'h0);   step(); step();
    check_outs("t4.hold", 1, 32'h8, 0, 32'h13, 32'h0, 0);
    drive(1, 1, 32'hDEAD, 0, 0, 32'h0); step();
    check_outs("t4.drop", 1, 32'h100, 0, 32'h13, 32'h0, 0);
    drive(1, 1, 32'hB0, 0, 0, 32'h0);   step();
    check_outs("t4.new", 1, 32'h104, 1, 32'hB0, 32'h100, 1);

    // flush, ack and pop in the same cycle
    drive(1, 1, 32'hB1, 0, 1, 32'h200); step();
    check_outs("t5.flush", 1, 32'h200, 0, 32'h13, 32'h0, 0);
    drive(1, 1, 32'hC0, 0, 0, 32'h0);   step();
    check_outs("t5.new", 1, 32'h204, 1, 32'hC0, 32'h200, 1);

    // reset while a request is outstanding with 3 entries queued
    drive(1, 1, 32'hC1, 1, 0, 32'h0);   step();
    drive(1, 1, 32'hC2, 1, 0, 32'h0);   step();
    drive(1, 0, 32'h0,  1, 0, 32'h0);   step();
    check_outs("t6.pre", 1, 32'h20C, 1, 32'hC0, 32'h200, 3);
    rst = 1'b0;                         step();
    check_outs("t6.rst", 0, 32'h0, 0, 32'h13, 32'h0, 0);
    rst = 1'b1;                         step();
    check_outs("t6.rel", 1, 32'h0, 0, 32'h13, 32'h0, 0);

    // random traffic vs reference model
    do_reset(); rst = 1'b1;
    mq.delete(); m_fpc = 32'h0; m_raddr = 32'h0; m_out = 1'b0; m_disc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic s, a, st, f;
      logic [31:0] d, r;
      ent_t h;
      s  = ($urandom % 8) != 0;
      a  = m_out && ($urandom % 2 == 0);
      st = ($urandom % 10) < 3;
      f  = ($urandom % 20) == 0;
      d  = $urandom;
      r  = $urandom & 32'hFFFF_FFFC;
      drive(s, a, d, st, f, r);
      model_step(s, a, d, st, f, r);
      step();
      h = (mq.size() > 0) ? mq[0] : '{pc: 32'h0, instr: 32'h13};
      check_outs($sformatf("rnd%0d", c), m_out, m_raddr, mq.size() > 0,
                 h.instr, h.pc, mq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
